// File: rtl/lod_denorm.sv
// lod_denorm: iterative denormalizer. This block reverses the leading-zero normalization step.
// A left-normalized vector is shifted right by its leading-zero count. The shift runs through
// a binary barrel shifter, one stage per clock, MSB stage first. The shift always takes
// exactly S cycles, whatever the count is.
//
// Optional feature, selected by the macro LOD_DENORM_STICKY_EN:
//   When the macro is defined, the block adds the out_sticky port. out_sticky is the OR of
//   every bit shifted out.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   input beat present
//   in_ready   block can accept a beat (high only in IDLE)
//   in_mant    normalized vector, N bits
//   in_lzc     leading-zero count, which is the right-shift amount (S bits)
//   in_vld     nonzero flag; 0 forces a zero result
//   out_valid  result present (high only in DONE)
//   out_ready  downstream accepts the result
//   out_data   denormalized vector, N bits
//   out_sticky OR of the discarded bits (only with LOD_DENORM_STICKY_EN)
//
// state | meaning
// IDLE  | waiting for a beat; in_ready=1
// SHIFT | one barrel stage per cycle, stage index k runs from S-1 down to 0
// DONE  | result held on out_data; out_valid=1 until out_ready
module lod_denorm #(
  parameter  int N = 8,
  localparam int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_mant,
  input  logic [S-1:0] in_lzc,
  input  logic         in_vld,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
`ifdef LOD_DENORM_STICKY_EN
  ,
  output logic         out_sticky
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // A count above N-1 can only occur when N is not a power of two. The block treats that
  // case the same as a zero value.
  localparam logic [S:0] LZC_MAX = (S+1)'(N-1);

  state_t       state, state_nxt;
  logic         accept;
  logic [N-1:0] sh_reg;
  logic [S-1:0] cnt_reg;
  logic [S-1:0] k_reg;
  logic [N-1:0] stage_data;
  int           stage_amt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (k_reg == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Current barrel stage: a shift by 2^k, applied only when count bit k is set.
  always_comb begin
    stage_amt  = 1 << k_reg;
    stage_data = sh_reg;
    if (cnt_reg[k_reg]) stage_data = sh_reg >> stage_amt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_reg  <= '0;
      cnt_reg <= '0;
      k_reg   <= '0;
    end else if (accept) begin
      sh_reg  <= (!in_vld || ({1'b0, in_lzc} > LZC_MAX)) ? '0 : in_mant;
      cnt_reg <= in_lzc;
      k_reg   <= S'(S-1);
    end else if (state == SHIFT) begin
      sh_reg  <= stage_data;
      k_reg   <= k_reg - 1'b1;
    end
  end

  assign out_data = sh_reg;

`ifdef LOD_DENORM_STICKY_EN
  logic stage_lost;
  logic sticky_reg;

  // Bits that fall off the bottom in this stage: the low 2^k bits, taken before the shift.
  always_comb begin
    stage_lost = 1'b0;
    if (cnt_reg[k_reg]) begin
      for (int i = 0; i < N; i++) begin
        if (i < stage_amt) stage_lost = stage_lost | sh_reg[i];
      end
    end
  end

  // A load that is forced to zero holds no set bits, so sticky stays 0 without extra logic.
  always_ff @(posedge clk) begin
    if (rst || accept)         sticky_reg <= 1'b0;
    else if (state == SHIFT)   sticky_reg <= sticky_reg | stage_lost;
  end

  assign out_sticky = sticky_reg;
`endif

endmodule

// File: tb/tb_lod_denorm.sv
module tb_lod_denorm;

  localparam int N = 8;
  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_vld, out_valid, out_ready;
  logic [7:0] in_mant, out_data;
  logic [2:0] in_lzc;
  logic       stk8;

  logic       in_valid6, in_ready6, in_vld6, out_valid6, out_ready6;
  logic [5:0] in_mant6, out_data6;
  logic [2:0] in_lzc6;
  logic       stk6;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lod_denorm #(.N(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_lzc(in_lzc), .in_vld(in_vld),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
`ifdef LOD_DENORM_STICKY_EN
    , .out_sticky(stk8)
`endif
  );

  lod_denorm #(.N(6)) dut6 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid6), .in_ready(in_ready6),
    .in_mant(in_mant6), .in_lzc(in_lzc6), .in_vld(in_vld6),
    .out_valid(out_valid6), .out_ready(out_ready6),
    .out_data(out_data6)
`ifdef LOD_DENORM_STICKY_EN
    , .out_sticky(stk6)
`endif
  );

`ifndef LOD_DENORM_STICKY_EN
  assign stk8 = 1'b0;
  assign stk6 = 1'b0;
`endif

  typedef struct {
    logic [7:0] mant;
    logic [2:0] lzc;
    logic       vld;
    int         hold;
    logic [7:0] exp_data;
    logic       exp_stk;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: the value before normalization is mant / 2^lzc. The sticky bit is set when the
  // remainder is nonzero. A zero flag gives a zero result.
  function automatic logic [8:0] ref8(input logic [7:0] m, input int l, input logic v);
    int mi, d, r;
    mi = int'(m);
    if (!v) return 9'd0;
    d = mi / (1 << l);
    r = mi % (1 << l);
    return {(r != 0), 8'(d)};
  endfunction

  task automatic run8(input logic [7:0] mant, input logic [2:0] lzc, input logic vld,
                      input int hold, input logic [7:0] exp_data, input logic exp_stk);
    int w, lat;
    @(negedge clk);
    in_mant = mant; in_lzc = lzc; in_vld = vld; in_valid = 1'b1; out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    check("accept_wait", (w < 20), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mant = 8'($urandom); in_lzc = 3'($urandom); in_vld = 1'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk); lat++;
      if (out_valid) break;
    end
    check("latency", lat, S + 1);
    check("out_data", out_data, exp_data);
`ifdef LOD_DENORM_STICKY_EN
    check("out_sticky", stk8, exp_stk);
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_data", out_data, exp_data);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  task automatic run6(input logic [5:0] mant, input logic [2:0] lzc, input logic vld,
                      input logic [5:0] exp_data, input logic exp_stk);
    int lat;
    @(negedge clk);
    in_mant6 = mant; in_lzc6 = lzc; in_vld6 = vld; in_valid6 = 1'b1; out_ready6 = 1'b0;
    check("n6_in_ready", in_ready6, 1);
    @(posedge clk); #1; in_valid6 = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk); lat++;
      if (out_valid6) break;
    end
    check("n6_latency", lat, S + 1);
    check("n6_out_data", out_data6, exp_data);
`ifdef LOD_DENORM_STICKY_EN
    check("n6_out_sticky", stk6, exp_stk);
`endif
    out_ready6 = 1'b1;
    @(posedge clk); #1; out_ready6 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int first, second, seen;
    logic [7:0] m;
    logic [2:0] l;
    logic v;
    logic [8:0] r;

    vecs[0] = '{8'hB0, 3'd2, 1'b1, 5, 8'h2C, 1'b0};
    vecs[1] = '{8'h80, 3'd7, 1'b1, 0, 8'h01, 1'b0};
    vecs[2] = '{8'hA5, 3'd0, 1'b1, 1, 8'hA5, 1'b0};
    vecs[3] = '{8'hFF, 3'd3, 1'b0, 0, 8'h00, 1'b0};
    vecs[4] = '{8'hB3, 3'd2, 1'b1, 2, 8'h2C, 1'b1};
    vecs[5] = '{8'h3C, 3'd5, 1'b1, 0, 8'h01, 1'b1};
    vecs[6] = '{8'h0F, 3'd4, 1'b1, 0, 8'h00, 1'b1};
    vecs[7] = '{8'hFF, 3'd1, 1'b1, 0, 8'h7F, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_mant = '0; in_lzc = '0; in_vld = 1'b0;
    in_valid6 = 1'b0; out_ready6 = 1'b0; in_mant6 = '0; in_lzc6 = '0; in_vld6 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_n6_out_data", out_data6, 0);
`ifdef LOD_DENORM_STICKY_EN
    check("rst_sticky", stk8, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run8(vecs[i].mant, vecs[i].lzc, vecs[i].vld, vecs[i].hold, vecs[i].exp_data, vecs[i].exp_stk);

    // With out_ready held high, a new beat is accepted every S+2 cycles.
    @(negedge clk);
    in_mant = 8'h80; in_lzc = 3'd7; in_vld = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    first = -1; second = -1;
    for (int c = 0; c < 16; c++) begin
      if (in_ready) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      @(negedge clk);
    end
    check("throughput", second - first, S + 2);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    out_ready = 1'b0;

    // Reset asserted in the second SHIFT cycle: the result is dropped and never presented.
    @(negedge clk);
    in_mant = 8'hB0; in_lzc = 3'd2; in_vld = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    seen = 0;
    out_ready = 1'b1;
    repeat (8) begin @(negedge clk); if (out_valid) seen = 1; end
    out_ready = 1'b0;
    check("midrst_no_pulse", seen, 0);

    for (int i = 0; i < 40; i++) begin
      m = 8'($urandom);
      if ($urandom_range(0, 3) != 0) m[7] = 1'b1;
      l = 3'($urandom_range(0, 7));
      v = ($urandom_range(0, 7) != 0);
      r = ref8(m, int'(l), v);
      run8(m, l, v, $urandom_range(0, 2), r[7:0], r[8]);
    end

    run6(6'h3F, 3'd7, 1'b1, 6'h00, 1'b0);
    run6(6'h3F, 3'd6, 1'b1, 6'h00, 1'b0);
    run6(6'h20, 3'd5, 1'b1, 6'h01, 1'b0);
    run6(6'h2C, 3'd3, 1'b1, 6'h05, 1'b1);
    run6(6'h3F, 3'd2, 1'b0, 6'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
